// File: rtl/mul_column_sequencer_if.sv
// Handshake and result bus of the column-sequential multiplier.
// The master drives start and the operands; the slave returns status and the product.
interface mul_column_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW);

  logic          start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;
  logic [CW-1:0] col;

  modport master (
    output start, a_in, b_in,
    input  busy, done, product, col
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, product, col
  );
endinterface

// File: rtl/mul_column_sequencer.sv
// Unsigned WIDTH x WIDTH multiplier that resolves one product column per clock
// through a single shared column slice. Optional macro MUL_ZERO_SKIP_EN bypasses COMPUTE for zero operands.
module mul_column_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input logic clk,
  input logic rst_n,
  mul_column_sequencer_if.slave bus
);
  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned CW  = $clog2(PW);
  localparam int unsigned IW  = $clog2(WIDTH);
  localparam int unsigned CRW = WIDTH - 1;
  localparam logic [CW-1:0] LAST_COL = CW'(PW - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CRW-1:0]  carry_q;
  logic [CRW-1:0]  carry_nxt;
  logic [WIDTH-1:0] pp;
  logic            col_sum;
  logic [PW-1:0]   product_q;
  logic [CW-1:0]   col_q;
  logic            busy_q;
  logic            done_q;

  // Column slice: AND partial products for column col_q, then a ripple of full adders.
  always_comb begin : slice_comb
    int   idx;
    logic acc;
    idx       = 0;
    acc       = 1'b0;
    pp        = '0;
    carry_nxt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      idx = int'(col_q) - i;
      if (idx >= 0 && idx < int'(WIDTH)) begin
        pp[i] = a_q[i] & b_q[IW'(idx)];
      end
    end
    acc = pp[0];
    for (int j = 0; j < int'(CRW); j++) begin
      {carry_nxt[j], acc} = 2'(acc) + 2'(pp[j+1]) + 2'(carry_q[j]);
    end
    col_sum = acc;
  end

  // Control FSM with registered status and product assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= '0;
      product_q <= '0;
      col_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q       <= bus.a_in;
            b_q       <= bus.b_in;
            carry_q   <= '0;
            product_q <= '0;
            col_q     <= '0;
            busy_q    <= 1'b1;
`ifdef MUL_ZERO_SKIP_EN
            if (bus.a_in == '0 || bus.b_in == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= COMPUTE;
            end
`else
            state <= COMPUTE;
`endif
          end
        end
        COMPUTE: begin
          product_q[col_q] <= col_sum;
          carry_q          <= carry_nxt;
          if (col_q == LAST_COL) begin
            col_q  <= '0;
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            col_q <= CW'(col_q + 1'b1);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // The top column can never produce carries; any carry here means the slice is broken.
  always_ff @(posedge clk) begin
    if (rst_n && state == COMPUTE && col_q == LAST_COL) begin
      assert (carry_nxt == '0)
        else $error("final column produced nonzero carry %0h", carry_nxt);
    end
  end
`endif

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.col     = col_q;
endmodule
